cim_bitserial_sequencer: RTL and testbench

Controller that runs one bit-serial MAC operation on the sparse CIM macro. It latches a vector of multi-bit activations and drives the macro word lines one bit plane at a time, MSB first. It captures the macro's column partial sum for each plane and accumulates the shift-weighted result. All-zero bit planes are skipped, so the macro is never fired for them. It sits between the activation buffer (start/ready handshake) and the result consumer (valid/ready handshake).

---
 rtl/cim_bitserial_sequencer_pkg.sv | 26 ++
 rtl/cim_bitserial_sequencer_if.sv | 39 +++
 rtl/cim_bitserial_sequencer_plane_select.sv | 28 ++
 rtl/cim_bitserial_sequencer.sv | 129 ++++++++++++
 tb/tb_cim_bitserial_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cim_bitserial_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// cim_seq_pkg : shared types and defaults for the CIM bit-serial sequencer
// Rev 1.0
// =============================================================================
package cim_seq_pkg;

  localparam int DEF_ROWS     = 16;
  localparam int DEF_ACT_BITS = 4;
  localparam int DEF_PS_W     = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    DRIVE  = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } seq_state_e;

  // Smallest accumulator that cannot overflow: max partial sum times max weight.
  function automatic int acc_w_min(input int ps_w, input int act_bits);
    return ps_w + act_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cim_bitserial_sequencer_if.sv
`default_nettype none
// =============================================================================
// cim_seq_if : activation/macro/result signal bundle of the CIM sequencer
// Rev 1.0
// =============================================================================
interface cim_seq_if
  import cim_seq_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int ACT_BITS = DEF_ACT_BITS,
  parameter int PS_W     = DEF_PS_W,
  parameter int ACC_W    = acc_w_min(DEF_PS_W, DEF_ACT_BITS)
);
  localparam int PF_W = $clog2(ACT_BITS + 1);

  logic                     start;
  logic                     ready;
  logic [ROWS*ACT_BITS-1:0] act_vec;
  logic [ROWS-1:0]          wl_bits;
  logic                     wl_en;
  logic [PS_W-1:0]          ps_in;
  logic [ACC_W-1:0]         result;
  logic                     out_valid;
  logic                     out_ready;
  logic [PF_W-1:0]          planes_fired;
  logic                     busy;

  modport master (
    output start, act_vec, ps_in, out_ready,
    input  ready, wl_bits, wl_en, result, out_valid, planes_fired, busy
  );

  modport slave (
    input  start, act_vec, ps_in, out_ready,
    output ready, wl_bits, wl_en, result, out_valid, planes_fired, busy
  );

endinterface
`default_nettype wire

// File: rtl/cim_bitserial_sequencer_plane_select.sv
`default_nettype none
// =============================================================================
// cim_plane_select : extracts one bit plane of the latched activations
// Rev 1.0
// =============================================================================
module cim_plane_select
  import cim_seq_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int ACT_BITS = DEF_ACT_BITS,
  parameter int BIT_W    = (DEF_ACT_BITS > 1) ? $clog2(DEF_ACT_BITS) : 1
)(
  input  wire logic [ROWS*ACT_BITS-1:0] act_i,
  input  wire logic [BIT_W-1:0]         bit_i,
  output logic      [ROWS-1:0]          plane_o,
  output logic                          plane_zero_o
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [ACT_BITS-1:0] w_row;
    assign w_row      = act_i[r*ACT_BITS +: ACT_BITS];
    assign plane_o[r] = w_row[bit_i];
  end

  assign plane_zero_o = (plane_o == '0);

endmodule
`default_nettype wire

// File: rtl/cim_bitserial_sequencer.sv
`default_nettype none
// =============================================================================
// cim_bitserial_sequencer : MSB-first bit-serial MAC control for the CIM macro
// Rev 1.0
// =============================================================================
module cim_bitserial_sequencer
  import cim_seq_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int ACT_BITS  = DEF_ACT_BITS,
  parameter int PS_W      = DEF_PS_W,
  parameter int ACC_W     = acc_w_min(DEF_PS_W, DEF_ACT_BITS),
  parameter int SKIP_ZERO = 1
)(
  input wire logic clk_1MHz,
  input wire logic rst,
  cim_seq_if.slave bus
);

  localparam int BIT_W     = (ACT_BITS > 1) ? $clog2(ACT_BITS) : 1;
  localparam int PF_W      = $clog2(ACT_BITS + 1);
  localparam int ACC_MIN   = acc_w_min(PS_W, ACT_BITS);
  localparam int ACC_INT_W = (ACC_W > ACC_MIN) ? ACC_W : ACC_MIN;
  localparam logic [BIT_W-1:0] C_TOP_BIT = BIT_W'(ACT_BITS - 1);

  seq_state_e               state_q, state_d;
  logic [ROWS*ACT_BITS-1:0] act_q, act_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [ACC_INT_W-1:0]     acc_q, acc_d;
  logic [PF_W-1:0]          pf_q, pf_d;
  logic [ROWS-1:0]          wl_bits_q, wl_bits_d;

  logic [ROWS-1:0]          w_plane;
  logic                     w_plane_zero;
  logic                     w_fire;
  logic                     w_last;

  cim_plane_select #(
    .ROWS     (ROWS),
    .ACT_BITS (ACT_BITS),
    .BIT_W    (BIT_W)
  ) u_plane_select (
    .act_i        (act_q),
    .bit_i        (bit_q),
    .plane_o      (w_plane),
    .plane_zero_o (w_plane_zero)
  );

  assign w_fire = !w_plane_zero || (SKIP_ZERO == 0);
  assign w_last = (bit_q == '0);

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    if (w_fire) state_d = DRIVE;
               else if (w_last) state_d = DONE;
      DRIVE:   state_d = SAMPLE;
      SAMPLE:  state_d = w_last ? DONE : SCAN;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready        = (state_q == IDLE);
    bus.busy         = (state_q != IDLE);
    bus.wl_en        = (state_q == DRIVE);
    bus.out_valid    = (state_q == DONE);
    bus.wl_bits      = wl_bits_q;
    bus.result       = acc_q[ACC_W-1:0];
    bus.planes_fired = pf_q;
  end

  // Datapath next-state; ps_in only reaches the accumulator in SAMPLE.
  always_comb begin
    act_d     = act_q;
    bit_d     = bit_q;
    acc_d     = acc_q;
    pf_d      = pf_q;
    wl_bits_d = wl_bits_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          act_d = bus.act_vec;
          bit_d = C_TOP_BIT;
          acc_d = '0;
          pf_d  = '0;
        end
      end
      SCAN: begin
        if (w_fire)       wl_bits_d = w_plane;
        else if (!w_last) bit_d     = bit_q - 1'b1;
      end
      SAMPLE: begin
        acc_d = acc_q + (ACC_INT_W'(bus.ps_in) << bit_q);
        pf_d  = pf_q + 1'b1;
        if (!w_last) bit_d = bit_q - 1'b1;
      end
      DONE: begin
        if (bus.out_ready) wl_bits_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      act_q     <= '0;
      bit_q     <= '0;
      acc_q     <= '0;
      pf_q      <= '0;
      wl_bits_q <= '0;
    end else begin
      act_q     <= act_d;
      bit_q     <= bit_d;
      acc_q     <= acc_d;
      pf_q      <= pf_d;
      wl_bits_q <= wl_bits_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cim_bitserial_sequencer.sv
`default_nettype none
// =============================================================================
// tb_cim_bitserial_sequencer : scoreboard bench for the CIM bit-serial sequencer
// Rev 1.0
// =============================================================================
module tb_cim_bitserial_sequencer;

  localparam int ROWS  = 16;
  localparam int AB    = 4;
  localparam int PS_W  = 5;
  localparam int ACC_W = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cim_seq_if #(.ROWS(ROWS), .ACT_BITS(AB), .PS_W(PS_W), .ACC_W(ACC_W)) a_if ();
  cim_seq_if #(.ROWS(ROWS), .ACT_BITS(AB), .PS_W(PS_W), .ACC_W(ACC_W)) b_if ();

  cim_bitserial_sequencer #(
    .ROWS(ROWS), .ACT_BITS(AB), .PS_W(PS_W), .ACC_W(ACC_W), .SKIP_ZERO(1)
  ) u_dut (
    .clk_1MHz (clk),
    .rst      (rst),
    .bus      (a_if)
  );

  cim_bitserial_sequencer #(
    .ROWS(ROWS), .ACT_BITS(AB), .PS_W(PS_W), .ACC_W(ACC_W), .SKIP_ZERO(0)
  ) u_dut_noskip (
    .clk_1MHz (clk),
    .rst      (rst),
    .bus      (b_if)
  );

  logic            start = 1'b0;
  logic            sel = 1'b0;
  logic            force31 = 1'b0;
  logic            out_rdy = 1'b1;
  logic [63:0]     act = '0;
  logic [PS_W-1:0] ps = '0;

  assign a_if.start     = start & ~sel;
  assign b_if.start     = start & sel;
  assign a_if.act_vec   = act;
  assign b_if.act_vec   = act;
  assign a_if.ps_in     = ps;
  assign b_if.ps_in     = ps;
  assign a_if.out_ready = out_rdy;
  assign b_if.out_ready = out_rdy;

  wire             m_ready  = sel ? b_if.ready        : a_if.ready;
  wire             m_busy   = sel ? b_if.busy         : a_if.busy;
  wire             m_wl_en  = sel ? b_if.wl_en        : a_if.wl_en;
  wire [ROWS-1:0]  m_wl     = sel ? b_if.wl_bits      : a_if.wl_bits;
  wire             m_valid  = sel ? b_if.out_valid    : a_if.out_valid;
  wire [ACC_W-1:0] m_result = sel ? b_if.result       : a_if.result;
  wire [2:0]       m_pf     = sel ? b_if.planes_fired : a_if.planes_fired;

  typedef struct packed {
    int res;
    int pf;
    int lat;
    int pulses;
    int acc_cyc;
    int base;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   pulses = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Macro model: answers one cycle after wl_en, drives junk at all other times.
  logic hold_ps = 1'b0;
  always @(negedge clk) begin
    if (m_wl_en) begin
      pulses++;
      ps = force31 ? 5'd31 : 5'($countones(m_wl));
      hold_ps = 1'b1;
    end else if (hold_ps) begin
      hold_ps = 1'b0;
    end else begin
      ps = 5'($urandom);
    end
  end

  // Monitor: pops one expectation on each rising out_valid.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (m_valid && !prev_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", int'(m_result), e.res);
          chk("planes_fired", int'(m_pf), e.pf);
          chk("latency", cyc - e.acc_cyc + 1, e.lat);
          chk("wl_en_pulses", pulses - e.base, e.pulses);
        end
      end
      prev_valid = m_valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!m_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(m_ready), 1);
  endtask

  task automatic accept(input logic [63:0] a);
    act   = a;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    act   = {$urandom, $urandom};
  endtask

  task automatic run_op(input logic [63:0] a, input logic s, input logic f31,
                        input logic hold, input int er, input int epf,
                        input int elat, input int epl);
    int n = 0;
    exp_t e;
    sel = s;
    force31 = f31;
    out_rdy = !hold;
    wait_ready();
    accept(a);
    e = '{res: er, pf: epf, lat: elat, pulses: epl, acc_cyc: cyc, base: pulses};
    q.push_back(e);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!m_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("valid_wait", int'(m_valid), 1);
    if (hold) begin
      for (int i = 0; i < 6; i++) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_result", int'(m_result), er);
        chk("hold_ready", int'(m_ready), 0);
        start = (i == 2);
        @(negedge clk);
      end
      start   = 1'b1;
      out_rdy = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("post_hs_valid", int'(m_valid), 0);
      chk("post_hs_ready", int'(m_ready), 1);
      chk("post_hs_busy", int'(m_busy), 0);
      @(negedge clk);
      chk("start_at_hs_ignored", int'(m_busy), 0);
    end else begin
      @(negedge clk);
      chk("idle_ready", int'(m_ready), 1);
      chk("idle_wl_bits", int'(m_wl), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(a_if.ready), 1);
    chk("rst_busy", int'(a_if.busy), 0);
    chk("rst_wl_en", int'(a_if.wl_en), 0);
    chk("rst_wl_bits", int'(a_if.wl_bits), 0);
    chk("rst_valid", int'(a_if.out_valid), 0);
    chk("rst_result", int'(a_if.result), 0);
    chk("rst_pf", int'(a_if.planes_fired), 0);
    rst = 1'b0;

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 240, 4, 13, 4);
    run_op(64'h4444_4444_4444_4444, 1'b0, 1'b0, 1'b0,  64, 1,  7, 1);
    run_op(64'h0,                   1'b0, 1'b0, 1'b0,   0, 0,  5, 0);
    run_op(64'h0,                   1'b1, 1'b0, 1'b0,   0, 4, 13, 4);
    run_op(64'h4444_4444_4444_4444, 1'b1, 1'b0, 1'b0,  64, 4, 13, 4);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 465, 4, 13, 4);
    run_op(64'h0000_0000_0000_000A, 1'b0, 1'b0, 1'b0,  10, 2,  9, 2);
    run_op(64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 1'b0, 120, 4, 13, 4);
    run_op(64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b1,  16, 1,  7, 1);

    // Abort an operation while the macro is being fired.
    sel = 1'b0;
    force31 = 1'b0;
    out_rdy = 1'b1;
    wait_ready();
    accept(64'hFFFF_FFFF_FFFF_FFFF);
    n = 0;
    @(negedge clk);
    while (!a_if.wl_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drive_reached", int'(a_if.wl_en), 1);
    rst = 1'b1;
    #1;
    chk("abort_wl_en", int'(a_if.wl_en), 0);
    chk("abort_busy", int'(a_if.busy), 0);
    chk("abort_ready", int'(a_if.ready), 1);
    chk("abort_pf", int'(a_if.planes_fired), 0);
    chk("abort_wl_bits", int'(a_if.wl_bits), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 240, 4, 13, 4);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
